// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch stage and imem.
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, single-outstanding imem fetch, IF/ID register, redirect flush.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect targets halt fetch and raise Misaligned.
//
// state      | meaning
// ST_REQ     | drive imem request (only while the skid is empty)
// ST_WAIT    | one request outstanding, response will be kept
// ST_DISCARD | one request outstanding, response will be dropped
// ST_HALT    | misaligned target seen, no fetching (macro build only)
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          PCNext_select,
  input  logic [31:0]         Target_Address,
  input  logic [31:0]         ALUResult,
  input  logic                Stall,
  fetch_unit_if.master        imem,
  output logic                IFID_valid,
  output logic [31:0]         IFID_instr,
  output logic [31:0]         IFID_pc,
  output logic [31:0]         IFID_pc_plus4,
  output logic                Flush
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic                Misaligned
`endif
);

  localparam logic [1:0] STEP_FORWARD                = 2'b00;
  localparam logic [1:0] JUMP_TO_LABEL               = 2'b01;
  localparam logic [1:0] JUMP_TO_CALCULATED_REGISTER = 2'b10;
  localparam logic [31:0] NOP_INSTR                  = 32'h0000_0013;

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_DISCARD, ST_HALT} state_t;
`else
  typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_DISCARD} state_t;
`endif

  state_t      state, state_next;
  logic [31:0] pc, pc_next, req_pc;
  logic [31:0] target_raw, target;
  logic        redirect, grant, rsp;
  logic        skid_valid;
  logic [31:0] skid_instr, skid_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  always_comb begin
    redirect   = (PCNext_select == JUMP_TO_LABEL) ||
                 (PCNext_select == JUMP_TO_CALCULATED_REGISTER);
    target_raw = (PCNext_select == JUMP_TO_CALCULATED_REGISTER) ?
                 (ALUResult & ~32'h1) : Target_Address;
`ifdef FETCH_MISALIGN_TRAP_EN
    target     = target_raw;
    misalign   = (target_raw[1:0] != 2'b00);
`else
    target     = target_raw & ~32'h3;
`endif
    imem.req   = rst_n && (state == ST_REQ) && !skid_valid;
    imem.addr  = pc;
    grant      = imem.req && imem.gnt;
    rsp        = (state == ST_WAIT) && imem.rvalid;
    Flush      = redirect;
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    case (state)
      ST_REQ: begin
        if (grant) begin
          state_next = ST_WAIT;
          pc_next    = pc + 32'd4;
        end
      end
      ST_WAIT:    if (imem.rvalid) state_next = ST_REQ;
      ST_DISCARD: if (imem.rvalid) state_next = ST_REQ;
      default:    state_next = state;
    endcase
    // A redirect beats everything; an outstanding request becomes a discard.
    if (redirect) begin
      pc_next = target;
      if (state == ST_REQ)
        state_next = grant ? ST_DISCARD : ST_REQ;
      else if ((state == ST_WAIT) || (state == ST_DISCARD))
        state_next = imem.rvalid ? ST_REQ : ST_DISCARD;
      else
        state_next = ST_REQ;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (misalign) state_next = ST_HALT;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_REQ;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_pc        <= 32'h0;
      skid_valid    <= 1'b0;
      skid_instr    <= 32'h0;
      skid_pc       <= 32'h0;
      IFID_valid    <= 1'b0;
      IFID_instr    <= NOP_INSTR;
      IFID_pc       <= 32'h0;
      IFID_pc_plus4 <= 32'h0;
    end else begin
      if (grant) req_pc <= pc;
      if (redirect) begin
        IFID_valid <= 1'b0;
        skid_valid <= 1'b0;
      end else if (!Stall) begin
        if (skid_valid) begin
          IFID_valid    <= 1'b1;
          IFID_instr    <= skid_instr;
          IFID_pc       <= skid_pc;
          IFID_pc_plus4 <= skid_pc + 32'd4;
          skid_valid    <= 1'b0;
        end else if (rsp) begin
          IFID_valid    <= 1'b1;
          IFID_instr    <= imem.rdata;
          IFID_pc       <= req_pc;
          IFID_pc_plus4 <= req_pc + 32'd4;
        end else begin
          IFID_valid    <= 1'b0;
        end
      end else if (rsp) begin
        skid_valid <= 1'b1;
        skid_instr <= imem.rdata;
        skid_pc    <= req_pc;
      end
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  assign Misaligned = (state == ST_HALT);
`endif

endmodule
